// File: rtl/ram_writer.sv
// ram_writer: stores DEPTH-lane PE result blocks into a byte-wide output RAM.
// Each handshaken block is buffered, then written one saturated byte per cycle
// at consecutive addresses. A pass covers the whole RAM, after which done is
// held until the next start.
module ram_writer #(
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int PE_DATA_WIDTH  = 16,
  parameter int DEPTH          = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0]    result_in,
  input  logic                              result_valid,
  output logic                              store_ready,
  output logic                              ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_address,
  output logic [RAM_DATA_WIDTH-1:0]         ram_wdata,
  output logic                              done
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BUF_W = PE_DATA_WIDTH * DEPTH;

  localparam logic [CNT_W-1:0]          LAST_LANE  = CNT_W'(DEPTH - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR  = {RAM_ADDR_WIDTH{1'b1}};
  localparam logic [RAM_ADDR_WIDTH-1:0] BLOCK_STEP = RAM_ADDR_WIDTH'(DEPTH);
  localparam logic [PE_DATA_WIDTH-1:0]  SAT_MAX    = PE_DATA_WIDTH'({RAM_DATA_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ARRAY = 2'd1,
    WRITE      = 2'd2,
    DONE       = 2'd3
  } state_t;

  // Clamp a signed PE result into the unsigned pixel byte range.
  function automatic logic [RAM_DATA_WIDTH-1:0] sat(input logic [PE_DATA_WIDTH-1:0] x);
    if (x[PE_DATA_WIDTH-1]) begin
      sat = {RAM_DATA_WIDTH{1'b0}};
    end else if (x > SAT_MAX) begin
      sat = {RAM_DATA_WIDTH{1'b1}};
    end else begin
      sat = x[RAM_DATA_WIDTH-1:0];
    end
  endfunction

  // Select lane k of a packed block of PE results.
  function automatic logic [PE_DATA_WIDTH-1:0] lane(input logic [BUF_W-1:0] v,
                                                    input logic [CNT_W-1:0] k);
    lane = v[int'(k)*PE_DATA_WIDTH +: PE_DATA_WIDTH];
  endfunction

  state_t                      state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0]   base_addr_q, base_addr_d;
  logic [CNT_W-1:0]            word_counter_q, word_counter_d;
  logic [BUF_W-1:0]            lane_buf_q, lane_buf_d;
  logic                        store_ready_q, store_ready_d;
  logic                        ram_we_q, ram_we_d;
  logic [RAM_ADDR_WIDTH-1:0]   ram_address_q, ram_address_d;
  logic [RAM_DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic                        done_q, done_d;
  logic [CNT_W-1:0]            next_lane_s;

  assign next_lane_s = word_counter_q + CNT_W'(1'b1);

  // State and registered outputs; reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      base_addr_q    <= {RAM_ADDR_WIDTH{1'b0}};
      word_counter_q <= {CNT_W{1'b0}};
      lane_buf_q     <= {BUF_W{1'b0}};
      store_ready_q  <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_address_q  <= {RAM_ADDR_WIDTH{1'b0}};
      ram_wdata_q    <= {RAM_DATA_WIDTH{1'b0}};
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_addr_q    <= base_addr_d;
      word_counter_q <= word_counter_d;
      lane_buf_q     <= lane_buf_d;
      store_ready_q  <= store_ready_d;
      ram_we_q       <= ram_we_d;
      ram_address_q  <= ram_address_d;
      ram_wdata_q    <= ram_wdata_d;
      done_q         <= done_d;
    end
  end

  // Next state plus the output values that will be visible after the next edge.
  always_comb begin
    state_d        = state_q;
    base_addr_d    = base_addr_q;
    word_counter_d = word_counter_q;
    lane_buf_d     = lane_buf_q;
    store_ready_d  = 1'b0;
    ram_we_d       = 1'b0;
    ram_address_d  = ram_address_q;
    ram_wdata_d    = ram_wdata_q;
    done_d         = done_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_addr_d   = {RAM_ADDR_WIDTH{1'b0}};
          state_d       = WAIT_ARRAY;
          store_ready_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      WAIT_ARRAY: begin
        if (result_valid && store_ready_q) begin
          // Capture edge: lane 0 goes out straight away, the rest come from the buffer.
          lane_buf_d     = result_in;
          word_counter_d = {CNT_W{1'b0}};
          state_d        = WRITE;
          ram_we_d       = 1'b1;
          ram_address_d  = base_addr_q;
          ram_wdata_d    = sat(lane(result_in, {CNT_W{1'b0}}));
        end else begin
          store_ready_d = 1'b1;
        end
      end

      WRITE: begin
        // word_counter_q is the lane currently on the RAM port.
        if (word_counter_q == LAST_LANE) begin
          base_addr_d = base_addr_q + BLOCK_STEP;
          if (ram_address_q == LAST_ADDR) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d       = WAIT_ARRAY;
            store_ready_d = 1'b1;
          end
        end else begin
          word_counter_d = next_lane_s;
          ram_we_d       = 1'b1;
          ram_address_d  = base_addr_q + RAM_ADDR_WIDTH'(next_lane_s);
          ram_wdata_d    = sat(lane(lane_buf_q, next_lane_s));
        end
      end

      DONE: begin
        if (start) begin
          done_d        = 1'b0;
          base_addr_d   = {RAM_ADDR_WIDTH{1'b0}};
          state_d       = WAIT_ARRAY;
          store_ready_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign store_ready = store_ready_q;
  assign ram_we      = ram_we_q;
  assign ram_address = ram_address_q;
  assign ram_wdata   = ram_wdata_q;
  assign done        = done_q;

endmodule
